// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional tx_done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter int          DATA_W         = 8,
   parameter int          MAX_BURST      = 4,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_busy,
   input  logic                      tx_done,
   output logic                      err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]     NUM_EXT   = (IDX_W+1)'(NUM_REQ);
   localparam logic [7:0]         BURST_LIM = 8'(MAX_BURST);
   localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    owner_nxt;
   logic [IDX_W-1:0]    last;
   logic [IDX_W-1:0]    last_nxt;
   logic [7:0]          burst_cnt;
   logic [7:0]          burst_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt;
   logic [NUM_REQ-1:0]  ack_nxt;
   logic                tx_start_nxt;
   logic [DATA_W-1:0]   tx_data_nxt;
   logic [IDX_W-1:0]    rr_idx;
   logic                rr_found;
   logic [IDX_W:0]      rr_cand;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0]         wd;
   logic [15:0]         wd_nxt;
   logic [15:0]         wd_inc;
   logic                err_q;
   logic                err_nxt;

   assign wd_inc = wd + 16'd1;
   assign err    = err_q;
`else
   // no watchdog: err is constant low
   assign err = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

   // scan farthest offset first so the nearest pending requester wins
   always_comb begin
      rr_idx   = last;
      rr_found = 1'b0;
      rr_cand  = '0;
      for (int o = NUM_REQ; o >= 1; o--) begin
         rr_cand = {1'b0, last} + (IDX_W+1)'(o);
         if (rr_cand >= NUM_EXT) begin
            rr_cand = rr_cand - NUM_EXT;
         end
         if (req[rr_cand[IDX_W-1:0]]) begin
            rr_idx   = rr_cand[IDX_W-1:0];
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last;
      burst_nxt    = burst_cnt;
      gnt_nxt      = gnt;
      ack_nxt      = '0;
      tx_start_nxt = 1'b0;
      tx_data_nxt  = tx_data;
`ifdef UART_ARB_TIMEOUT_EN
      wd_nxt       = wd;
      err_nxt      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (rr_found) begin
               owner_nxt = rr_idx;
               gnt_nxt   = ONE << rr_idx;
               burst_nxt = 8'd0;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            if (!req[owner]) begin
               gnt_nxt   = '0;
               last_nxt  = owner;
               state_nxt = IDLE;
            end else if (!tx_busy) begin
               tx_data_nxt  = req_data[int'(owner)*DATA_W +: DATA_W];
               tx_start_nxt = 1'b1;
               ack_nxt      = ONE << owner;
               if (burst_cnt != 8'hFF) begin
                  burst_nxt = burst_cnt + 8'd1;
               end
               state_nxt = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
               wd_nxt = 16'd0;
`endif
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               if (burst_cnt < BURST_LIM) begin
                  state_nxt = LAUNCH;
               end else begin
                  gnt_nxt   = '0;
                  last_nxt  = owner;
                  state_nxt = IDLE;
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (wd_inc == TIMEOUT_CYCLES) begin
               err_nxt   = 1'b1;
               gnt_nxt   = '0;
               last_nxt  = owner;
               state_nxt = IDLE;
            end else begin
               wd_nxt = wd_inc;
            end
`endif
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= LAST_RST;
         burst_cnt <= 8'd0;
         gnt       <= '0;
         ack       <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         wd        <= 16'd0;
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_nxt;
         gnt       <= gnt_nxt;
         ack       <= ack_nxt;
         tx_start  <= tx_start_nxt;
         tx_data   <= tx_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
         wd        <= wd_nxt;
         err_q     <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed cases plus randomized
// byte queues checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int          N  = 4;
   localparam int          W  = 8;
   localparam int          MB = 4;
   localparam logic [15:0] TO = 16'd100;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   ack;
   logic [N-1:0]   gnt;
   logic           tx_start;
   logic [W-1:0]   tx_data;
   logic           tx_busy;
   logic           tx_done;
   logic           err;

   logic [N-1:0]   req1;
   logic [N*W-1:0] req_data1;
   logic [N-1:0]   ack1;
   logic [N-1:0]   gnt1;
   logic           tx_start1;
   logic [W-1:0]   tx_data1;
   logic           tx_busy1;
   logic           tx_done1;
   logic           err1;

   int checks = 0;
   int failures = 0;
   int ack_cnt[N];
   bit err_ok = 1'b0;

   logic [7:0] q[N][$];
   int m_last;
   int m_owner;
   int m_cnt;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done), .err(err)
   );

   uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_W(W), .MAX_BURST(1), .TIMEOUT_CYCLES(TO)
   ) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .req_data(req_data1),
      .ack(ack1), .gnt(gnt1), .tx_start(tx_start1), .tx_data(tx_data1),
      .tx_busy(tx_busy1), .tx_done(tx_done1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("ack_without_start", 32'((ack != '0) && !tx_start), 0);
      if (tx_start) chk("ack_onehot", 32'($onehot(ack)), 1);
      chk("gnt1_onehot0", 32'($onehot0(gnt1)), 1);
      chk("err1_low", 32'(err1), 0);
      if (!err_ok) chk("err_low", 32'(err), 0);
      for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
      req1 = '0; req_data1 = '0; tx_busy1 = 1'b0; tx_done1 = 1'b0;
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_err", 32'(err), 0);
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      rst = 1'b1;
   endtask

   // lat = cycles from the stimulus change (req rise or tx_done raise)
   task automatic wait_start(input int lat, input int e, input logic [7:0] d,
                             input string tag);
      for (int k = 1; k <= lat; k++) begin
         step();
         tx_done = 1'b0;
         if (k < lat) chk({tag, "_early_start"}, 32'(tx_start), 0);
      end
      chk({tag, "_start"}, 32'(tx_start), 1);
      chk({tag, "_ack"}, 32'(ack), 32'(1 << e));
      chk({tag, "_gnt"}, 32'(gnt), 32'(1 << e));
      chk({tag, "_data"}, 32'(tx_data), 32'(d));
   endtask

   task automatic finish_frame(input int d);
      tx_busy = 1'b1;
      for (int k = 0; k < d; k++) begin
         step();
         chk("frame_quiet", 32'(tx_start), 0);
      end
      tx_busy = 1'b0;
      tx_done = 1'b1;
   endtask

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         req[i] = (q[i].size() > 0);
         req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      end
   endtask

   function automatic int rr(input int from);
      for (int o = 1; o <= N; o++) begin
         if (q[(from + o) % N].size() > 0) return (from + o) % N;
      end
      return -1;
   endfunction

   initial begin
      int e;
      int lat;
      bit first;
      bit found;
      int order[5];
      order = '{0, 1, 2, 3, 0};

      // single requester, first arbitration after reset
      do_reset();
      req = 4'b0001;
      req_data = 32'h0000_00A5;
      step();
      chk("a_gnt", 32'(gnt), 32'h1);
      chk("a_no_start", 32'(tx_start), 0);
      step();
      chk("a_start", 32'(tx_start), 1);
      chk("a_ack", 32'(ack), 32'h1);
      chk("a_data", 32'(tx_data), 32'hA5);
      req = '0;
      finish_frame(5);
      step();
      tx_done = 1'b0;
      step();
      chk("a_release", 32'(gnt), 0);
      chk("a_data_hold", 32'(tx_data), 32'hA5);

      // tx_done while idle is ignored
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      chk("idle_done_gnt", 32'(gnt), 0);
      chk("idle_done_start", 32'(tx_start), 0);

      // two requesters held, bursts of MB bytes each
      do_reset();
      req = 4'b0011;
      req_data = 32'h0000_3130;
      for (int b = 0; b < 2 * MB; b++) begin
         e = (b < MB) ? 0 : 1;
         lat = (b == 0) ? 2 : ((b == MB) ? 3 : 2);
         wait_start(lat, e, 8'h30 + 8'(e), "burst");
         if (b == 2 * MB - 1) req = '0;
         finish_frame(3);
      end
      step();
      tx_done = 1'b0;
      repeat (3) step();
      chk("burst_ack0", ack_cnt[0], MB);
      chk("burst_ack1", ack_cnt[1], MB);
      chk("burst_idle", 32'(gnt), 0);

      // transmitter busy holds the launch
      do_reset();
      tx_busy = 1'b1;
      req = 4'b0100;
      req_data = 32'h00C2_0000;
      step();
      chk("busy_gnt", 32'(gnt), 32'h4);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("busy_hold", 32'(tx_start), 0);
      end
      tx_busy = 1'b0;
      step();
      chk("busy_start", 32'(tx_start), 1);
      chk("busy_ack", 32'(ack), 32'h4);
      chk("busy_data", 32'(tx_data), 32'hC2);

      // asynchronous reset during WAIT_DONE of requester 2
      req = 4'b1110;
      req_data = 32'hD3D2_D1D0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_ack", 32'(ack), 0);
      chk("arst_start", 32'(tx_start), 0);
      chk("arst_data", 32'(tx_data), 0);
      chk("arst_err", 32'(err), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      chk("arst_next_gnt", 32'(gnt), 32'h2);
      chk("arst_no_start", 32'(tx_start), 0);
      step();
      chk("arst_next_start", 32'(tx_start), 1);
      chk("arst_next_ack", 32'(ack), 32'h2);
      chk("arst_next_data", 32'(tx_data), 32'hD1);

      // withheld tx_done
      do_reset();
      req = 4'b0011;
      req_data = 32'h0000_6160;
      wait_start(2, 0, 8'h60, "wd");
`ifdef UART_ARB_TIMEOUT_EN
      err_ok = 1'b1;
      for (int k = 1; k < int'(TO); k++) begin
         step();
         chk("wd_early_err", 32'(err), 0);
      end
      step();
      chk("wd_err", 32'(err), 1);
      chk("wd_gnt_clear", 32'(gnt), 0);
      step();
      chk("wd_err_pulse", 32'(err), 0);
      chk("wd_next_gnt", 32'(gnt), 32'h2);
      err_ok = 1'b0;
      step();
      chk("wd_next_start", 32'(tx_start), 1);
      chk("wd_next_data", 32'(tx_data), 32'h61);
`else
      repeat (int'(TO) + 20) step();
      chk("wd_off_hold_gnt", 32'(gnt), 32'h1);
      chk("wd_off_no_start", 32'(tx_start), 0);
`endif

      // MAX_BURST=1 instance interleaves strictly
      do_reset();
      req1 = 4'b1111;
      req_data1 = 32'h5352_5150;
      for (int b = 0; b < 5; b++) begin
         found = 1'b0;
         for (int k = 0; k < 20; k++) begin
            step();
            tx_done1 = 1'b0;
            if (tx_start1) begin
               found = 1'b1;
               break;
            end
         end
         chk("il_found", 32'(found), 1);
         chk("il_gnt", 32'(gnt1), 32'(1 << order[b]));
         chk("il_ack", 32'(ack1), 32'(1 << order[b]));
         chk("il_data", 32'(tx_data1), 32'(8'h50 + 8'(order[b])));
         repeat (9) step();
         tx_done1 = 1'b1;
      end
      step();
      tx_done1 = 1'b0;

      // randomized queues against the transaction-level model
      do_reset();
      m_last = N - 1;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) q[i].push_back(8'($urandom));
         end
         if (rr(0) < 0) q[$urandom_range(0, N - 1)].push_back(8'($urandom));
         drive_req();
         first = 1'b1;
         m_cnt = 0;
         m_owner = m_last;
         while (rr(0) >= 0) begin
            if (first) begin
               e = rr(m_last);
               lat = 2;
               m_cnt = 0;
               first = 1'b0;
            end else if (q[m_owner].size() > 0 && m_cnt < MB) begin
               e = m_owner;
               lat = 2;
            end else begin
               lat = (m_cnt >= MB) ? 3 : 4;
               m_last = m_owner;
               e = rr(m_last);
               m_cnt = 0;
            end
            wait_start(lat, e, q[e][0], "rnd");
            void'(q[e].pop_front());
            m_cnt++;
            m_owner = e;
            drive_req();
            finish_frame($urandom_range(1, 12));
         end
         step();
         tx_done = 1'b0;
         repeat (3) step();
         chk("rnd_idle", 32'(gnt), 0);
         m_last = m_owner;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
